// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters, registered syncs/de,
// line/frame strobes, frame counter and an optional clk-based output delay.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CW_X     = 10,
    parameter int CW_Y     = 10,
    parameter int PIPE_DLY = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic            enable,
    output logic            h_sync,
    output logic            v_sync,
    output logic            de,
    output logic [CW_X-1:0] x,
    output logic [CW_Y-1:0] y,
    output logic            line_start,
    output logic            frame_start,
    output logic [7:0]      frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);
    localparam logic [4:0] CTL_OFF = {~HS_ON, ~VS_ON, 3'b000};

    generate
        if ($clog2(H_TOTAL) > CW_X) begin : g_bad_cw_x
            $error("CW_X too narrow for H_TOTAL");
        end
        if ($clog2(V_TOTAL) > CW_Y) begin : g_bad_cw_y
            $error("CW_Y too narrow for V_TOTAL");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
            $error("PIPE_DLY must be 0..7");
        end
    endgenerate

    logic [CW_X-1:0] hc_q, hc_d, x_q, x_d;
    logic [CW_Y-1:0] vc_q, vc_d, y_q, y_d;
    logic [7:0]      fcnt_q, fcnt_d;
    logic            de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic            ls_q, ls_d, fs_q, fs_d;
    logic            h_wrap, v_wrap;
    logic [4:0]      ctl;

    always_comb begin
        h_wrap = (int'(hc_q) == H_TOTAL - 1);
        v_wrap = (int'(vc_q) == V_TOTAL - 1);
        hc_d   = hc_q;
        vc_d   = vc_q;
        fcnt_d = fcnt_q;
        x_d    = x_q;
        y_d    = y_q;
        de_d   = de_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        ls_d   = 1'b0;
        fs_d   = 1'b0;
        if (!enable) begin
            hc_d = '0;
            vc_d = '0;
            x_d  = '0;
            y_d  = '0;
            de_d = 1'b0;
            hs_d = ~HS_ON;
            vs_d = ~VS_ON;
        end else if (ce) begin
            hc_d = h_wrap ? '0 : hc_q + 1'b1;
            if (h_wrap) begin
                vc_d = v_wrap ? '0 : vc_q + 1'b1;
                if (v_wrap) fcnt_d = fcnt_q + 8'd1;
            end
            // Output stage samples the counters before they advance
            x_d  = hc_q;
            y_d  = vc_q;
            de_d = (int'(hc_q) < H_ACTIVE) && (int'(vc_q) < V_ACTIVE);
            hs_d = (int'(hc_q) >= HS_BEG && int'(hc_q) < HS_END)
                   ? HS_ON : ~HS_ON;
            vs_d = (int'(vc_q) >= VS_BEG && int'(vc_q) < VS_END)
                   ? VS_ON : ~VS_ON;
            ls_d = (hc_q == '0);
            fs_d = (hc_q == '0) && (vc_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q   <= '0;
            vc_q   <= '0;
            fcnt_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
            de_q   <= 1'b0;
            hs_q   <= ~HS_ON;
            vs_q   <= ~VS_ON;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            fcnt_q <= fcnt_d;
            x_q    <= x_d;
            y_q    <= y_d;
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

    assign ctl       = {hs_q, vs_q, de_q, ls_q, fs_q};
    assign x         = x_q;
    assign y         = y_q;
    assign frame_cnt = fcnt_q;

    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign {h_sync, v_sync, de, line_start, frame_start} = ctl;
        end else begin : g_dly
            logic [4:0] dly_q [PIPE_DLY];
            logic [4:0] dly_d [PIPE_DLY];

            // Free-running on clk so the line drains while stopped
            always_comb begin
                dly_d[0] = ctl;
                for (int i = 1; i < PIPE_DLY; i++) dly_d[i] = dly_q[i-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE_DLY; i++) dly_q[i] <= CTL_OFF;
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign {h_sync, v_sync, de, line_start, frame_start} =
                dly_q[PIPE_DLY-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small 14x7 raster, positive syncs, 3-clk delay,
// reference model feeding a scoreboard plus direct period/latency checks.
module tb_vga_timing_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b1;
    logic       enable = 1'b0;
    logic       h_sync, v_sync, de, line_start, frame_start;
    logic [3:0] x;
    logic [2:0] y;
    logic [7:0] frame_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(1), .CW_X(4), .CW_Y(3), .PIPE_DLY(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .enable(enable),
        .h_sync(h_sync), .v_sync(v_sync), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    typedef struct {
        logic [3:0] x;
        logic [2:0] y;
        logic [7:0] fc;
        logic [4:0] ctl;
    } exp_t;

    exp_t       sb_q[$];
    int         mhc, mvc;
    logic [7:0] mfc;
    logic [3:0] mx;
    logic [2:0] my;
    logic [4:0] r;
    logic [4:0] s [3];

    // Reference raster: 14 clk/line, 7 lines/frame, hsync at 10..11, vsync at line 5
    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            mhc = 0; mvc = 0; mfc = 8'd0; mx = 4'd0; my = 3'd0;
            r = 5'b0;
            for (int i = 0; i < 3; i++) s[i] = 5'b0;
            sb_q.delete();
        end else begin
            s[2] = s[1]; s[1] = s[0]; s[0] = r;
            if (!enable) begin
                mhc = 0; mvc = 0; mx = 4'd0; my = 3'd0; r = 5'b0;
            end else if (ce) begin
                mx = mhc[3:0];
                my = mvc[2:0];
                r = {(mhc >= 10 && mhc < 12), (mvc == 5),
                     (mhc < 8 && mvc < 4), (mhc == 0),
                     (mhc == 0 && mvc == 0)};
                mhc++;
                if (mhc == 14) begin
                    mhc = 0;
                    mvc++;
                    if (mvc == 7) begin
                        mvc = 0;
                        mfc++;
                    end
                end
            end else begin
                r[1] = 1'b0;
                r[0] = 1'b0;
            end
        end
        e.x = mx; e.y = my; e.fc = mfc; e.ctl = s[2];
        sb_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        check_eq("sb_depth", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("x", x, e.x);
            check_eq("y", y, e.y);
            check_eq("frame_cnt", frame_cnt, e.fc);
            check_eq("ctl", {h_sync, v_sync, de, line_start, frame_start},
                     e.ctl);
        end
    end

    function automatic logic sig(input int k);
        return (k == 0) ? frame_start : line_start;
    endfunction

    task automatic wait_sig(input int k, input string tag, input int budget,
                            output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(k) && n < budget);
        if (!sig(k)) check_eq(tag, sig(k), 1);
    endtask

    initial begin
        int n, w;
        logic [7:0] fc;
        repeat (3) @(negedge clk);
        check_eq("rst_de", de, 0);
        check_eq("rst_fc", frame_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        wait_sig(0, "fs_first", 200, n);
        wait_sig(0, "fs_period", 200, n);
        check_eq("frame_period", n, 98);
        wait_sig(1, "ls_a", 50, n);
        wait_sig(1, "ls_b", 50, n);
        check_eq("line_period", n, 14);
        repeat (257 * 98) @(negedge clk);

        fork
            begin
                repeat (240) begin
                    @(negedge clk);
                    ce = ~ce;
                end
            end
            begin
                wait_sig(1, "ls_ce_a", 100, n);
                w = 0;
                while (line_start && w < 10) begin
                    @(negedge clk);
                    w++;
                end
                check_eq("ls_width_ce2", w, 1);
                wait_sig(1, "ls_ce_b", 100, n);
                check_eq("line_period_ce2", w + n, 28);
            end
        join
        ce = 1'b1;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(x == 4'd5 && y == 3'd3) && n < 200);
        check_eq("reach_x5y3", {x, y}, {4'd5, 3'd3});
        enable = 1'b0;
        fc = frame_cnt;
        repeat (6) @(negedge clk);
        check_eq("fc_hold", frame_cnt, fc);
        check_eq("stop_xy", {x, y}, 7'd0);
        enable = 1'b1;
        wait_sig(0, "fs_restart", 10, n);
        check_eq("fs_latency", n, 4);
        check_eq("x_at_fs", x, 3);

        repeat (40) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_x", x, 0);
        check_eq("async_fc", frame_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_sig(0, "fs_after_rst", 10, n);
        check_eq("fs_rst_latency", n, 4);
        repeat (50) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
